// File: rtl/bit_index_assembler_if.sv
// Valid/ready bundle between an index-beat producer and the mask assembler.
// The producer (master) sends index beats and accepts finished masks.
interface bit_index_assembler_if #(
    parameter int WIDTH = 32,
    parameter int IDX_W = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] in_idx;
    logic             in_last;
    logic             in_skip;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_mask;
    logic [IDX_W:0]   out_count;
    logic             out_dup;
    logic             out_err;

    modport master (
        output in_valid, in_idx, in_last, in_skip, out_ready,
        input  in_ready, out_valid, out_mask, out_count, out_dup, out_err
    );

    modport slave (
        input  in_valid, in_idx, in_last, in_skip, out_ready,
        output in_ready, out_valid, out_mask, out_count, out_dup, out_err
    );
endinterface

// File: rtl/bit_index_assembler.sv
// Rebuilds a bit mask from a frame of set-bit indices; reports distinct-bit
// count plus duplicate and out-of-range flags once the frame's last beat lands.
module bit_index_assembler #(
    parameter int WIDTH = 32,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input logic                  clk,
    input logic                  rst_n,
    bit_index_assembler_if.slave bus
);
    // state     | meaning
    // S_COLLECT | accepting index beats, accumulating the mask
    // S_HOLD    | finished frame presented downstream, input stalled
    typedef enum logic {
        S_COLLECT = 1'b0,
        S_HOLD    = 1'b1
    } state_t;

    localparam logic [IDX_W:0]   WIDTH_L = (IDX_W + 1)'(WIDTH);
    localparam logic [IDX_W:0]   ONE_L   = (IDX_W + 1)'(1);
    localparam logic [WIDTH-1:0] BIT0    = {{(WIDTH - 1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [IDX_W:0]   count_q, count_d;
    logic             dup_q, dup_d;
    logic             err_q, err_d;

    logic             accept;
    logic             in_range;
    logic             already_set;
    logic [WIDTH-1:0] onehot;

    assign accept      = bus.in_valid && (state_q == S_COLLECT);
    assign in_range    = {1'b0, bus.in_idx} < WIDTH_L;
    // Shifting past the top drops to zero, so out-of-range indices never alias a bit.
    assign onehot      = BIT0 << bus.in_idx;
    assign already_set = |(mask_q & onehot);

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        count_d = count_q;
        dup_d   = dup_q;
        err_d   = err_q;
        case (state_q)
            S_COLLECT: begin
                if (accept) begin
                    if (!bus.in_skip) begin
                        if (!in_range) begin
                            err_d = 1'b1;
                        end else if (already_set) begin
                            dup_d = 1'b1;
                        end else begin
                            mask_d  = mask_q | onehot;
                            count_d = count_q + ONE_L;
                        end
                    end
                    if (bus.in_last) begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    state_d = S_COLLECT;
                    mask_d  = '0;
                    count_d = '0;
                    dup_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_COLLECT;
            mask_q  <= '0;
            count_q <= '0;
            dup_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            dup_q   <= dup_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready  = (state_q == S_COLLECT);
    assign bus.out_valid = (state_q == S_HOLD);
    assign bus.out_mask  = mask_q;
    assign bus.out_count = count_q;
    assign bus.out_dup   = dup_q;
    assign bus.out_err   = err_q;
endmodule
